// File: rtl/rtc_time_editor.sv
// User-side hh:mm:ss editor: snapshot live BCD time, step fields, commit via req/ack.
// Optional inactivity timeout enabled by defining RTC_EDITOR_TIMEOUT_EN.
module rtc_time_editor #(
  parameter logic [7:0]  SEC_MAX   = 8'h59,
  parameter logic [7:0]  MIN_MAX   = 8'h59,
  parameter logic [7:0]  HOUR_MAX  = 8'h23,
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edit_req,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_ok,
  input  logic       btn_cancel,
  input  logic       tick_1hz,
  input  logic [7:0] cur_sec,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_hour,
  output logic [7:0] ed_sec,
  output logic [7:0] ed_min,
  output logic [7:0] ed_hour,
  output logic [1:0] field_sel,
  output logic       editing,
  output logic       wr_req,
  input  logic       wr_ack
);

  localparam int unsigned BCD_W = 8;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EDIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BCD_W-1:0] sec_q, sec_d;
  logic [BCD_W-1:0] min_q, min_d;
  logic [BCD_W-1:0] hour_q, hour_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             editing_q, editing_d;
  logic             wr_req_q, wr_req_d;

  logic             adj_up, adj_dn, mv_right, mv_left, any_btn;
  logic [SEL_W-1:0] sel_eff;

  // Out-of-range or non-BCD snapshot fields load zero
  function automatic logic [BCD_W-1:0] bcd_sanitise(input logic [BCD_W-1:0] v,
                                                    input logic [BCD_W-1:0] lim);
    if ((v[7:4] > 4'h9) || (v[3:0] > 4'h9) || (v > lim)) return 8'h00;
    return v;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v,
                                               input logic [BCD_W-1:0] lim);
    if (v == lim)          return 8'h00;
    if (v[3:0] == 4'h9)    return {v[7:4] + 4'h1, 4'h0};
    return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v,
                                               input logic [BCD_W-1:0] lim);
    if (v == 8'h00)        return lim;
    if (v[3:0] == 4'h0)    return {v[7:4] - 4'h1, 4'h9};
    return {v[7:4], v[3:0] - 4'h1};
  endfunction

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v,
                                                  input logic [BCD_W-1:0] lim,
                                                  input logic up, input logic dn);
    if (up) return bcd_inc(v, lim);
    if (dn) return bcd_dec(v, lim);
    return v;
  endfunction

  assign adj_up   = btn_up & ~btn_down;
  assign adj_dn   = btn_down & ~btn_up;
  assign mv_right = btn_right & ~btn_left;
  assign mv_left  = btn_left & ~btn_right;
  assign any_btn  = |{btn_up, btn_down, btn_left, btn_right, btn_ok, btn_cancel};
  // An illegal selection of 3 behaves as seconds when moving
  assign sel_eff  = (sel_q == 2'd3) ? 2'd0 : sel_q;

`ifdef RTC_EDITOR_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_fire;

  assign tmo_fire = (state_q == ST_EDIT) && !any_btn && tick_1hz &&
                    (tmo_q == TMO_W'(TIMEOUT_S - 1));
`else
  logic unused_cfg;
  assign unused_cfg = tick_1hz | (TIMEOUT_S == 32'd0);
`endif

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    sel_d   = sel_q;
`ifdef RTC_EDITOR_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (edit_req) begin
          state_d = ST_EDIT;
          sec_d   = bcd_sanitise(cur_sec, SEC_MAX);
          min_d   = bcd_sanitise(cur_min, MIN_MAX);
          hour_d  = bcd_sanitise(cur_hour, HOUR_MAX);
          sel_d   = 2'd0;
`ifdef RTC_EDITOR_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ST_EDIT: begin
        if (btn_cancel) begin
          state_d = ST_IDLE;
        end else if (btn_ok) begin
          state_d = ST_WRITE;
        end else begin
          case (sel_q)
            2'd0:    sec_d  = bcd_adjust(sec_q, SEC_MAX, adj_up, adj_dn);
            2'd1:    min_d  = bcd_adjust(min_q, MIN_MAX, adj_up, adj_dn);
            2'd2:    hour_d = bcd_adjust(hour_q, HOUR_MAX, adj_up, adj_dn);
            default: ;
          endcase
          if (mv_right)     sel_d = (sel_eff == 2'd2) ? 2'd0 : sel_eff + 2'd1;
          else if (mv_left) sel_d = (sel_eff == 2'd0) ? 2'd2 : sel_eff - 2'd1;
        end
`ifdef RTC_EDITOR_TIMEOUT_EN
        if (any_btn) begin
          tmo_d = '0;
        end else if (tick_1hz) begin
          tmo_d = tmo_fire ? '0 : tmo_q + TMO_W'(1);
        end
        if (tmo_fire) state_d = ST_IDLE;
`endif
      end
      ST_WRITE: begin
        if (wr_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    editing_d = (state_d != ST_IDLE);
    wr_req_d  = (state_d == ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      hour_q    <= 8'h00;
      sel_q     <= 2'd0;
      editing_q <= 1'b0;
      wr_req_q  <= 1'b0;
`ifdef RTC_EDITOR_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      sel_q     <= sel_d;
      editing_q <= editing_d;
      wr_req_q  <= wr_req_d;
`ifdef RTC_EDITOR_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign ed_sec    = sec_q;
  assign ed_min    = min_q;
  assign ed_hour   = hour_q;
  assign field_sel = sel_q;
  assign editing   = editing_q;
  assign wr_req    = wr_req_q;

endmodule
